// File: rtl/cla_addsub_pipe_if.sv
// Handshake and data bundle for the pipelined CLA adder/subtractor.
// The producer/consumer side uses master, the arithmetic core uses slave.
interface cla_addsub_pipe_if #(
    parameter int unsigned WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             sub;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
    logic             zero;

    modport master (
        output in_valid, a, b, sub, cin, out_ready,
        input  in_ready, out_valid, sum, cout, ovf, zero
    );

    modport slave (
        input  in_valid, a, b, sub, cin, out_ready,
        output in_ready, out_valid, sum, cout, ovf, zero
    );
endinterface

// File: rtl/cla_addsub_pipe.sv
// Pipelined carry-lookahead adder/subtractor with valid/ready handshake.
// Each stage resolves PIPE_GROUPS lookahead groups; operand bits that are
// not yet processed are skewed forward, finished sum bits ride along so the
// whole result leaves the last stage together with its flags.
module cla_addsub_pipe #(
    parameter int unsigned WIDTH       = 16,
    parameter int unsigned GROUP       = 4,
    parameter int unsigned PIPE_GROUPS = 2
) (
    input  logic             clk,
    input  logic             reset,
    cla_addsub_pipe_if.slave bus
);
    localparam int unsigned NGRP = WIDTH / GROUP;
    localparam int unsigned SPAN = GROUP * PIPE_GROUPS;
    localparam int unsigned NS   = (NGRP + PIPE_GROUPS - 1) / PIPE_GROUPS;

    logic             advance;
    logic [WIDTH-1:0] b_eff;
    logic             c0;

    assign b_eff = bus.sub ? ~bus.b : bus.b;
    assign c0    = bus.sub | bus.cin;

    for (genvar k = 0; k < NS; k++) begin : g_stg
        localparam int unsigned LO = k * SPAN;
        localparam int unsigned HI = (LO + SPAN > WIDTH) ? WIDTH : LO + SPAN;
        localparam int unsigned W  = HI - LO;
        localparam int unsigned NG = W / GROUP;

        logic          v_in;
        logic          c_in;
        logic [W-1:0]  sa;
        logic [W-1:0]  sb;
        logic [W-1:0]  s_slice;
        logic [NG:0]   gc;
        logic [HI-1:0] sum_d;
        logic          bg, bp, p, cj;
        logic          v_q;
        logic          c_q;
        logic [HI-1:0] sum_q;

        if (k == 0) begin : g_src
            assign v_in  = bus.in_valid;
            assign c_in  = c0;
            assign sa    = bus.a[HI-1:LO];
            assign sb    = b_eff[HI-1:LO];
            assign sum_d = s_slice;
        end else begin : g_src
            assign v_in  = g_stg[k-1].v_q;
            assign c_in  = g_stg[k-1].c_q;
            assign sa    = g_stg[k-1].g_rest.a_q[HI-1:LO];
            assign sb    = g_stg[k-1].g_rest.b_q[HI-1:LO];
            assign sum_d = {s_slice, g_stg[k-1].sum_q};
        end

        // Group carries chain by G | P*cin; bit carries inside a group come
        // from the group-entry carry and the prefix G/P of the lower bits.
        always_comb begin
            gc      = '0;
            s_slice = '0;
            bg      = 1'b0;
            bp      = 1'b1;
            p       = 1'b0;
            cj      = 1'b0;
            gc[0]   = c_in;
            for (int unsigned g = 0; g < NG; g++) begin
                bg = 1'b0;
                bp = 1'b1;
                for (int unsigned j = 0; j < GROUP; j++) begin
                    p  = sa[g*GROUP+j] ^ sb[g*GROUP+j];
                    cj = bg | (bp & gc[g]);
                    s_slice[g*GROUP+j] = p ^ cj;
                    bg = (sa[g*GROUP+j] & sb[g*GROUP+j]) | (p & bg);
                    bp = bp & p;
                end
                gc[g+1] = bg | (bp & gc[g]);
            end
        end

        // Stage valid, carry out and accumulated sum bits; hold on stall.
        always_ff @(posedge clk) begin
            if (reset) begin
                v_q   <= 1'b0;
                c_q   <= 1'b0;
                sum_q <= '0;
            end else if (advance) begin
                v_q   <= v_in;
                c_q   <= gc[NG];
                sum_q <= sum_d;
            end
        end

        if (HI < WIDTH) begin : g_rest
            logic [WIDTH-1:HI] a_q;
            logic [WIDTH-1:HI] b_q;
            logic [WIDTH-1:HI] a_in;
            logic [WIDTH-1:HI] b_in;

            if (k == 0) begin : g_skew_src
                assign a_in = bus.a[WIDTH-1:HI];
                assign b_in = b_eff[WIDTH-1:HI];
            end else begin : g_skew_src
                assign a_in = g_stg[k-1].g_rest.a_q[WIDTH-1:HI];
                assign b_in = g_stg[k-1].g_rest.b_q[WIDTH-1:HI];
            end

            // Skew the still-unprocessed operand bits to the next stage.
            always_ff @(posedge clk) begin
                if (advance) begin
                    a_q <= a_in;
                    b_q <= b_in;
                end
            end
        end

        if (k == NS - 1) begin : g_flags
            logic ovf_q;
            logic zero_q;

            // Carry into the MSB is recovered from its sum bit and operands.
            always_ff @(posedge clk) begin
                if (reset) begin
                    ovf_q  <= 1'b0;
                    zero_q <= 1'b0;
                end else if (advance) begin
                    ovf_q  <= sa[W-1] ^ sb[W-1] ^ s_slice[W-1] ^ gc[NG];
                    zero_q <= ~|sum_d;
                end
            end
        end
    end

    assign advance       = !g_stg[NS-1].v_q || bus.out_ready;
    assign bus.in_ready  = advance;
    assign bus.out_valid = g_stg[NS-1].v_q;
    assign bus.sum       = g_stg[NS-1].sum_q;
    assign bus.cout      = g_stg[NS-1].c_q;
    assign bus.ovf       = g_stg[NS-1].g_flags.ovf_q;
    assign bus.zero      = g_stg[NS-1].g_flags.zero_q;
endmodule

// File: doc/cla_addsub_pipe.md
# cla_addsub_pipe

Parametrised, pipelined carry-lookahead adder/subtractor: the successor to our fixed 6-bit combinational CLA. It is generalised in operand width, lookahead group size and pipeline depth. It adds a subtract mode, status flags and a valid/ready handshake with backpressure. It is the arithmetic core the iterative divider datapath instantiates for its trial subtraction, and it is also usable stand-alone at one result per cycle.

## Interface
Parameters:
- WIDTH, 16: operand/result width. Must be a multiple of GROUP and ≥ GROUP.
- GROUP, 4: bits per lookahead group. Generate/propagate are computed and the carry is resolved by lookahead within a group.
- PIPE_GROUPS, 2: lookahead groups per pipeline stage. Stage count NS = ceil((WIDTH/GROUP)/PIPE_GROUPS).

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- in_valid  in  1  operands valid
- in_ready  out  1  block can accept operands this cycle
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- sub  in  1  0: A+B+cin; 1: A−B (A+~B+1, cin ignored)
- cin  in  1  carry in, add mode only
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- sum  out  WIDTH  result, modulo 2^WIDTH
- cout  out  1  carry out of MSB (subtract mode: 1 = no borrow, i.e. A ≥ B unsigned)
- ovf  out  1  two's-complement signed overflow
- zero  out  1  sum == 0

## Operation
- Effective operand B' = sub ? ~b : b; effective carry in c0 = sub ? 1 : cin.
- Stage k (0..NS−1) resolves bit groups [k·PIPE_GROUPS, (k+1)·PIPE_GROUPS) using the carry registered out of stage k−1; stage 0 uses c0.
- Inside a stage, groups chain by lookahead: group carry = G | P·c_in. No ripple across more than one group's P/G term.
- Not-yet-processed operand bits are skewed through per-stage registers. Computed sum bits are carried forward, so all WIDTH bits of a result leave the final stage together.
- Flags are computed from the final-stage values:
  - ovf = carry into MSB XOR carry out of MSB.
  - zero = ~|sum.
  - cout = carry out of MSB.
- Each stage holds a valid bit. Bubbles propagate as valid=0, and data registers of invalid stages are don't-care.
- Global stall: advance = !out_valid | out_ready. When advance=0, every stage register holds and in_ready=0. in_ready = advance, which is combinational from out_ready.
- Transfer in occurs when in_valid & in_ready. Transfer out occurs when out_valid & out_ready.
- Results emerge in issue order; there is no reordering or dropping.

## Timing
- Latency: an operand accepted at edge t appears at the outputs after edge t+NS−1, i.e. visible during cycle t+NS when unstalled. Defaults: NS=2.
- Throughput: one operation per cycle while out_ready stays high.
- A stall of n cycles delays every in-flight result by exactly n cycles. While stalled, out_valid, sum, cout, ovf and zero stay stable.
- Reset, including assertion mid-stream, takes effect at the next clk edge:
  - all stage valid bits and out_valid go to 0;
  - sum, cout, ovf and zero go to 0;
  - in-flight operations are discarded;
  - in_ready = 1 in the first cycle after reset deasserts.
- A simultaneous in-transfer and out-transfer in the same cycle is legal and loses nothing.
- Operations are independent: wrap-around at 2^WIDTH is defined arithmetic, not an error.

## Test plan
- Default parameters, add mode: 0xFFFF+0x0001, cin=0 → sum 0x0000, cout 1, zero 1, ovf 0, out_valid exactly 2 cycles after accept.
- Signed overflow: 0x7FFF+0x0001 → sum 0x8000, ovf 1, cout 0. Subtract 0x8000−0x0001 → sum 0x7FFF, ovf 1, cout 1.
- Subtract borrow: 5−7 → sum 0xFFFE, cout 0, zero 0. Subtract 7−7 with cin=1 → sum 0, zero 1, cout 1 (cin ignored).
- Backpressure: stream 8 back-to-back ops and drop out_ready for 3 cycles mid-stream → in_ready low exactly during the stall, outputs frozen, all 8 results in order with none lost or duplicated.
- Reset mid-operation: assert reset for 1 cycle with 2 ops in flight → out_valid 0 and all outputs 0 next cycle, neither op ever emerges, and a new op after reset completes normally.
- WIDTH=6, GROUP=2, PIPE_GROUPS=1 (NS=3): exhaustive 4096 A/B pairs in both modes with random out_ready → each {cout,sum} equals A+B (or A+~B+1), and flags match the golden model.
